count_sched: RTL and testbench

COUNT_SCHED -- requirements
Module: count_sched

---
 rtl/count_sched_pkg.sv | 21 ++
 rtl/count_sched_rr_pick.sv | 28 ++
 rtl/count_sched.sv | 126 ++++++++++++
 tb/tb_count_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/count_sched_pkg.sv
// rtl/count_sched_pkg.sv - shared state type, default counter width and round-robin pick function
package count_sched_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  // Returns {found, index[2:0]}; searches n requesters starting just after last.
  function automatic logic [3:0] rr_pick_fn(input logic [7:0] req, input int n,
                                            input logic [2:0] last);
    logic [3:0] r;
    r = '0;
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (int'(last) + k) % n;
      if (k <= n && !r[3] && req[idx]) r = {1'b1, idx[2:0]};
    end
    return r;
  endfunction

endpackage

// File: rtl/count_sched_rr_pick.sv
// rtl/count_sched_rr_pick.sv - combinational round-robin picker (module rr_pick)
module rr_pick
  import count_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] winner_onehot,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);

  logic [7:0] req_ext;
  logic [3:0] pick;

  always_comb begin
    req_ext = '0;
    req_ext[N_REQ-1:0] = req;
    pick = rr_pick_fn(req_ext, N_REQ, 3'(last_winner));
    valid = pick[3];
    winner_idx = pick[IDX_W-1:0];
    winner_onehot = '0;
    for (int i = 0; i < N_REQ; i++) winner_onehot[i] = valid && (pick[2:0] == 3'(i));
  end

endmodule

// File: rtl/count_sched.sv
// rtl/count_sched.sv - round-robin shared counter scheduler; COUNT_SCHED_PAUSE_EN adds a pause input
module count_sched
  import count_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*CNT_W-1:0]     len,
  input  logic                       select,
`ifdef COUNT_SCHED_PAUSE_EN
  input  logic                       pause,
`endif
  output logic [N_REQ-1:0]           grant,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_REQ)-1:0]   done_id,
  output logic                       abort,
  output logic [3:0]                 count_out
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t           state, state_d;
  logic [IDX_W-1:0] winner, winner_d, last_winner, last_winner_d;
  logic [CNT_W-1:0] counter, counter_d, target, target_d, cnt_inc, len_sel;
  logic [N_REQ-1:0] grant_d, win_oh, pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid, abort_d, hold;

`ifdef COUNT_SCHED_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req          (req),
    .last_winner  (last_winner),
    .winner_onehot(pick_oh),
    .winner_idx   (pick_idx),
    .valid        (pick_valid)
  );

  assign cnt_inc = counter + CNT_W'(1);
  assign len_sel = len[int'(winner)*CNT_W +: CNT_W];

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < N_REQ; i++) win_oh[i] = (winner == IDX_W'(i));
  end

  always_comb begin
    state_d       = state;
    winner_d      = winner;
    last_winner_d = last_winner;
    counter_d     = counter;
    target_d      = target;
    abort_d       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          winner_d = pick_idx;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        counter_d = '0;
        target_d  = len_sel;
        state_d   = (len_sel == '0) ? DONE : RUN;
        if (!req[winner]) begin
          abort_d       = 1'b1;
          last_winner_d = winner;
          state_d       = IDLE;
        end
      end
      RUN: begin
        // An owner dropping its request wins over completion, even while paused.
        if (!req[winner]) begin
          abort_d       = 1'b1;
          last_winner_d = winner;
          state_d       = IDLE;
        end else if (!hold) begin
          counter_d = cnt_inc;
          if (cnt_inc == target) state_d = DONE;
        end
      end
      DONE: begin
        last_winner_d = winner;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    grant_d = '0;
    if (state_d == LOAD || state_d == RUN) grant_d = (state == IDLE) ? pick_oh : win_oh;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      winner      <= '0;
      last_winner <= IDX_W'(N_REQ - 1);
      counter     <= '0;
      target      <= '0;
      grant       <= '0;
      abort       <= 1'b0;
      count_out   <= '0;
    end else begin
      state       <= state_d;
      winner      <= winner_d;
      last_winner <= last_winner_d;
      counter     <= counter_d;
      target      <= target_d;
      grant       <= grant_d;
      abort       <= abort_d;
      count_out   <= select ? ~counter_d[3:0] : counter_d[3:0];
    end
  end

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign done_id = (state == DONE) ? winner : '0;

endmodule

// File: tb/tb_count_sched.sv
// tb/tb_count_sched.sv - self-checking bench for count_sched (table vectors, hand sequences, random vs model)
module tb_count_sched;

  logic        clk = 0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] len;
  logic        select;
  logic        pause;
  logic [3:0]  grant;
  logic        busy, done, abort;
  logic [1:0]  done_id;
  logic [3:0]  count_out;

  int n_vec = 0;
  int n_bad = 0;
  int last_w = 3;

  always #5 clk = ~clk;

  count_sched #(.N_REQ(4), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .len      (len),
    .select   (select),
`ifdef COUNT_SCHED_PAUSE_EN
    .pause    (pause),
`endif
    .grant    (grant),
    .busy     (busy),
    .done     (done),
    .done_id  (done_id),
    .abort    (abort),
    .count_out(count_out)
  );

  typedef struct {
    logic [3:0]  req;
    logic [63:0] len;
    bit          sel;
    int          abort_at;
    int          exp_id;
    int          exp_len;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack_len(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  function automatic logic [3:0] nib(input int v, input bit sel);
    logic [3:0] n;
    n = 4'(v);
    return sel ? ~n : n;
  endfunction

  // One grant from IDLE: LOAD, exp_len RUN cycles, DONE; or an abort when req is dropped at cycle abort_at.
  task automatic run_txn(input logic [3:0] r, input logic [63:0] l, input bit sel,
                         input int abort_at, input int exp_id, input int exp_len);
    req = r; len = l; select = sel;
    for (int j = 0; j <= exp_len; j++) begin
      step();
      chk("grant", grant, 64'(4'b0001 << exp_id));
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      if (j > 0) chk("count_out", count_out, nib(j - 1, sel));
      if (j == abort_at) begin
        req[exp_id] = 1'b0;
        step();
        chk("abort_pulse", abort, 1);
        chk("abort_grant", grant, 0);
        chk("abort_no_done", done, 0);
        req = '0;
        step();
        chk("abort_end", abort, 0);
        last_w = exp_id;
        return;
      end
    end
    step();
    chk("done", done, 1);
    chk("done_id", done_id, exp_id);
    chk("done_grant", grant, 0);
    chk("done_count", count_out, nib(exp_len, sel));
    req = '0;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    last_w = exp_id;
  endtask

  task automatic do_reset();
    reset = 1; req = '0; len = '0; select = 0; pause = 0;
    step();
    step();
    reset = 0;
    last_w = 3;
  endtask

  initial begin
    int ids[$];
    int gap, g, lens[4], w, ab;
    logic [3:0] r;
    bit sel, seen;

    tbl[0] = '{4'b0001, pack_len(3, 0, 0, 0), 0, -1, 0, 3};
    tbl[1] = '{4'b0100, pack_len(0, 0, 0, 0), 0, -1, 2, 0};
    tbl[2] = '{4'b0010, pack_len(0, 10, 0, 0), 0, 4, 1, 10};
    tbl[3] = '{4'b1101, pack_len(2, 2, 2, 2), 0, -1, 2, 2};
    tbl[4] = '{4'b0001, pack_len(20, 0, 0, 0), 1, -1, 0, 20};
    tbl[5] = '{4'b1111, pack_len(5, 6, 7, 8), 0, -1, 1, 6};
    tbl[6] = '{4'b1001, pack_len(1, 1, 1, 4), 0, 0, 3, 4};
    tbl[7] = '{4'b1001, pack_len(2, 0, 0, 1), 1, -1, 0, 2};

    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_abort", abort, 0);
    chk("rst_count", count_out, 0);

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].req, tbl[i].len, tbl[i].sel, tbl[i].abort_at, tbl[i].exp_id, tbl[i].exp_len);

    // Fairness: all requesting, length 1 -> one grant every 4 cycles in index order.
    do_reset();
    req = 4'b1111; len = pack_len(1, 1, 1, 1);
    gap = 0;
    for (int c = 0; c < 60 && ids.size() < 5; c++) begin
      step();
      gap++;
      if (done) begin
        ids.push_back(int'(done_id));
        if (ids.size() > 1) chk("fair_gap", gap, 4);
        gap = 0;
      end
    end
    chk("fair_count", ids.size(), 5);
    for (int i = 0; i < ids.size() && i < 5; i++) chk("fair_id", ids[i], i % 4);
    req = '0;
    step();
    step();

    // Reset in the middle of a count.
    do_reset();
    req = 4'b0001; len = pack_len(10, 0, 0, 0);
    step(); step(); step();
    reset = 1;
    step();
    reset = 0; req = '0;
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_abort", abort, 0);
    chk("mid_rst_count", count_out, 0);
    step();
    chk("mid_rst_nopulse", {done, abort}, 0);
    last_w = 3;
    run_txn(4'b0011, pack_len(2, 2, 0, 0), 0, -1, 0, 2);

`ifdef COUNT_SCHED_PAUSE_EN
    req = 4'b0001; len = pack_len(4, 0, 0, 0);
    g = 0; seen = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      step();
      if (grant != 0) g++;
      if (done) seen = 1;
      pause = (g >= 2 && g <= 4 && grant != 0);
    end
    pause = 0; req = '0;
    chk("pause_done", seen, 1);
    chk("pause_grant_len", g, 8);
    step();
    last_w = 0;
`endif

    // Random transactions checked against the round-robin rule.
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) lens[k] = $urandom_range(0, 6);
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && r[(last_w + k) % 4]) w = (last_w + k) % 4;
      ab = ($urandom % 4 == 0) ? $urandom_range(0, lens[w]) : -1;
      sel = 1'($urandom % 2);
      run_txn(r, pack_len(lens[0], lens[1], lens[2], lens[3]), sel, ab, w, lens[w]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
